paralelo_serial: RTL

Byte-to-serial transmitter for the PHY link, and the transmit end of the comma-aligned serial lane. It accepts parallel bytes through a valid/ready handshake and shifts them out MSB-first, one bit per `clk_32f` cycle. At start-up it sends `SYNC_COUNT` comma bytes (0xBC) so the far-end receiver can lock. When no data is pending it fills the lane with the idle comma.

---
 rtl/phy_pkg.sv | 12 +
 rtl/paralelo_serial.sv | 132 +++++++++++++
 2 files changed

// File: rtl/phy_pkg.sv
// rtl/phy_pkg.sv - constants and state encoding shared by the PHY serial link transmitter and receiver
package phy_pkg;

   localparam logic [7:0] IDLE_CHAR_DEFAULT  = 8'hBC;
   localparam int         SYNC_COUNT_DEFAULT = 4;

   typedef enum logic {
      SYNC   = 1'b0,
      ACTIVE = 1'b1
   } phy_state_e;

endpackage

// File: rtl/paralelo_serial.sv
// rtl/paralelo_serial.sv - byte-to-serial lane transmitter with comma sync preamble and idle fill
// Bytes enter a single-entry hold register and are shifted out MSB-first, one bit per clk_32f.
module paralelo_serial
   import phy_pkg::*;
#(
   parameter logic [7:0]  IDLE_CHAR  = IDLE_CHAR_DEFAULT,
   parameter int unsigned SYNC_COUNT = SYNC_COUNT_DEFAULT
) (
   input  logic       clk_32f,
   input  logic       reset_L,
   input  logic [7:0] data_in,
   input  logic       valid_in,
   output logic       ready_out,
   output logic       data_out,
   output logic       active_out,
   output logic       collision_out
);

   localparam logic [3:0] SYNC_LAST = 4'(SYNC_COUNT - 1);

   phy_state_e r_state;
   phy_state_e w_state_next;

   logic [2:0] r_bit_cnt;
   logic [7:0] r_shift_reg;
   logic [7:0] r_hold_reg;
   logic       r_hold_full;
   logic [3:0] r_sync_cnt;
   logic       r_active;
   logic       r_collision;

   logic       w_boundary;
   logic       w_accept;
   logic       w_drain;
   logic       w_sync_inc;
   logic       w_active_next;
   logic [7:0] w_load_byte;

   assign w_boundary = (r_bit_cnt == 3'd7);
   assign w_accept   = valid_in && !r_hold_full;

   always_ff @(posedge clk_32f or negedge reset_L) begin
      if (!reset_L) begin
         r_state <= SYNC;
      end else begin
         r_state <= w_state_next;
      end
   end

   // Leave SYNC on the boundary that loads the last preamble comma.
   always_comb begin
      w_state_next = r_state;
      unique case (r_state)
         SYNC: begin
            if (w_boundary && (r_sync_cnt == SYNC_LAST)) begin
               w_state_next = ACTIVE;
            end
         end
         ACTIVE: begin
            w_state_next = ACTIVE;
         end
         default: begin
            w_state_next = SYNC;
         end
      endcase
   end

   always_comb begin
      w_active_next = 1'b0;
      w_sync_inc    = 1'b0;
      w_drain       = 1'b0;
      w_load_byte   = IDLE_CHAR;
      unique case (r_state)
         SYNC: begin
            w_sync_inc = w_boundary;
         end
         ACTIVE: begin
            w_active_next = 1'b1;
            w_drain       = w_boundary && r_hold_full;
            if (r_hold_full) begin
               w_load_byte = r_hold_reg;
            end
         end
         default: begin
            w_active_next = 1'b0;
         end
      endcase
   end

   always_ff @(posedge clk_32f or negedge reset_L) begin
      if (!reset_L) begin
         r_bit_cnt   <= 3'd0;
         r_shift_reg <= 8'd0;
         r_sync_cnt  <= 4'd0;
         r_active    <= 1'b0;
      end else begin
         r_bit_cnt <= r_bit_cnt + 3'd1;
         if (w_boundary) begin
            r_shift_reg <= w_load_byte;
         end else begin
            r_shift_reg <= {r_shift_reg[6:0], 1'b0};
         end
         if (w_sync_inc) begin
            r_sync_cnt <= r_sync_cnt + 4'd1;
         end
         r_active <= w_active_next;
      end
   end

   // Accept and drain are mutually exclusive: accept needs an empty holder, drain a full one.
   always_ff @(posedge clk_32f or negedge reset_L) begin
      if (!reset_L) begin
         r_hold_reg  <= 8'd0;
         r_hold_full <= 1'b0;
         r_collision <= 1'b0;
      end else begin
         if (w_accept) begin
            r_hold_reg  <= data_in;
            r_hold_full <= 1'b1;
         end else if (w_drain) begin
            r_hold_full <= 1'b0;
         end
         r_collision <= w_accept && (data_in == IDLE_CHAR);
      end
   end

   assign ready_out     = !r_hold_full;
   assign data_out      = r_shift_reg[7];
   assign active_out    = r_active;
   assign collision_out = r_collision;

endmodule
